// File: rtl/demux_pkg.sv
// Shared types for the 1-to-3 stream demultiplexer.
//   dest_e : per-beat destination select carried with each input beat
//   NUM_CH : number of output channels
package demux_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef enum logic [1:0] {
    DEST_A       = 2'd0,
    DEST_B       = 2'd1,
    DEST_C       = 2'd2,
    DEST_ILLEGAL = 2'd3
  } dest_e;

endpackage : demux_pkg

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register for a single demux channel.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : accept load_data this cycle (only asserted while free)
//   load_data  : payload to capture
//   out_ready  : downstream ready
//   out_valid  : registered valid
//   out_data   : registered payload, stable while stalled
//   free       : combinational, entry can take a beat this cycle
module demux_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Empty, or draining this cycle so a new beat can replace it.
  assign free = !valid_q || out_ready;

  // Next-state: load wins over drain, giving one beat per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule : demux_out_reg

// File: rtl/demux3_stream_router.sv
// Registered 1-to-3 stream demultiplexer with illegal-select accounting.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake; in_ready is combinational
//   in_sel, in_data     : destination select (3 = illegal) and payload
//   out_valid/out_ready : per-channel handshake, bit0=A bit1=B bit2=C
//   out_data            : per-channel payload, slice k = [k*DATA_W +: DATA_W]
//   err_pulse           : one-cycle pulse per dropped illegal beat
//   err_flag, err_cnt   : sticky flag and saturating count of illegal beats
//   err_clr             : synchronous clear of err_flag/err_cnt
module demux3_stream_router
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     err_pulse,
  output logic                     err_flag,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  input  logic                     err_clr
);

  dest_e                dest;
  logic [NUM_CH-1:0]    free_c;
  logic [NUM_CH-1:0]    load_c;
  logic                 illegal_acc_c;

  logic                 err_pulse_q, err_pulse_d;
  logic                 err_flag_q,  err_flag_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  assign dest = dest_e'(in_sel);

  // Routing: legal beats wait for their channel, illegal beats are always taken.
  always_comb begin
    in_ready      = 1'b0;
    load_c        = '0;
    illegal_acc_c = 1'b0;
    unique case (dest)
      DEST_A: begin
        in_ready  = free_c[0];
        load_c[0] = in_valid && free_c[0];
      end
      DEST_B: begin
        in_ready  = free_c[1];
        load_c[1] = in_valid && free_c[1];
      end
      DEST_C: begin
        in_ready  = free_c[2];
        load_c[2] = in_valid && free_c[2];
      end
      default: begin
        in_ready      = 1'b1;
        illegal_acc_c = in_valid;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_out_reg #(.DATA_W(DATA_W)) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .free      (free_c[k])
    );
  end

  // Error tracking: a new illegal beat takes priority over a clear.
  always_comb begin
    err_pulse_d = illegal_acc_c;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      err_flag_d = illegal_acc_c;
      err_cnt_d  = illegal_acc_c ? ERR_CNT_W'(1) : '0;
    end else if (illegal_acc_c) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;

endmodule : demux3_stream_router

// File: tb/tb_demux3_stream_router.sv
// Scoreboard bench for demux3_stream_router: directed scenarios followed by
// random traffic, checked against a per-channel queue model.
module tb_demux3_stream_router;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned NCH       = 3;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_sel;
  logic [DATA_W-1:0]        in_data;
  logic [NCH-1:0]           out_valid;
  logic [NCH-1:0]           out_ready;
  logic [NCH*DATA_W-1:0]    out_data;
  logic                     err_pulse;
  logic                     err_flag;
  logic [ERR_CNT_W-1:0]     err_cnt;
  logic                     err_clr;

  demux3_stream_router #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is a FIFO of at most one pending beat.
  logic [DATA_W-1:0] exp_q [NCH][$];
  int                m_cnt;
  bit                m_flag;
  bit                m_pulse;
  int                n_cmp;
  int                n_bad;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_cnt   = 0;
    m_flag  = 0;
    m_pulse = 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the values
  // that the next posedge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_flag",  32'(err_flag),  32'd0);
      chk("rst_err_cnt",   32'(err_cnt),   32'd0);
      for (int k = 0; k < int'(NCH); k++) exp_q[k].delete();
      m_cnt   = 0;
      m_flag  = 0;
      m_pulse = 0;
    end else begin
      bit exp_rdy;
      bit acc;
      bit ill;
      for (int k = 0; k < int'(NCH); k++)
        chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("err_flag",  32'(err_flag),  32'(m_flag));
      chk("err_cnt",   32'(err_cnt),   32'(m_cnt));

      if (in_sel == 2'd3) exp_rdy = 1'b1;
      else exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
      if (in_valid) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = in_valid && exp_rdy;
      ill = acc && (in_sel == 2'd3);

      // Drain first, then enqueue: a drained slot can take the new beat.
      for (int k = 0; k < int'(NCH); k++) begin
        if (exp_q[k].size() != 0 && out_ready[k]) begin
          chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(exp_q[k][0]));
          void'(exp_q[k].pop_front());
        end
      end
      if (acc && !ill) exp_q[in_sel].push_back(in_data);

      m_pulse = ill;
      if (err_clr) begin
        m_flag = ill;
        m_cnt  = ill ? 1 : 0;
      end else if (ill) begin
        m_flag = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [2:0] rdy, input bit clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    err_clr   = clr;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 3'b111;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat to A.
    drive(1, 2'd0, 8'h5A, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);

    // Stalled B does not block C.
    drive(1, 2'd1, 8'h11, 3'b101, 0);
    drive(1, 2'd1, 8'h22, 3'b101, 0);
    drive(1, 2'd2, 8'h33, 3'b101, 0);
    drive(0, 2'd0, 8'h00, 3'b101, 0);
    drive(0, 2'd0, 8'h00, 3'b101, 0);
    drive(1, 2'd1, 8'h22, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);

    // Full-rate stream to A.
    for (int i = 0; i < 4; i++) drive(1, 2'd0, 8'(8'hA0 + i), 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);

    // Three illegal beats back to back.
    for (int i = 0; i < 3; i++) drive(1, 2'd3, 8'hEE, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 0);

    // Saturate the counter, then clear together with a new error.
    for (int i = 0; i < 260; i++) drive(1, 2'd3, 8'h00, 3'b111, 0);
    drive(1, 2'd3, 8'h00, 3'b111, 1);
    drive(0, 2'd0, 8'h00, 3'b111, 0);
    drive(0, 2'd0, 8'h00, 3'b111, 1);
    drive(0, 2'd0, 8'h00, 3'b111, 0);

    // Mid-stream reset with A and C holding beats.
    drive(1, 2'd0, 8'hAA, 3'b000, 0);
    drive(1, 2'd2, 8'hCC, 3'b000, 0);
    drive(1, 2'd3, 8'h00, 3'b000, 0);
    drive(0, 2'd0, 8'h00, 3'b000, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)), 8'($urandom),
            3'($urandom_range(7, 0)), ($urandom_range(15, 0) == 0));
    end
    for (int i = 0; i < 4; i++) drive(0, 2'd0, 8'h00, 3'b111, 0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_demux3_stream_router

// File: doc/demux3_stream_router.md
# demux3_stream_router

Registered 1-to-3 stream demultiplexer: the inverse of the team's 3:1 select mux. One input valid/ready stream carries a 2-bit select with each beat. The block routes the beat to one of three output channels, each backed by a one-entry output register. Select value 2'b11 is illegal: the beat is consumed, dropped and counted. The block sits between a command source and three downstream consumers.

## Interface
- DATA_W, 8, payload width in bits
- ERR_CNT_W, 8, width of the illegal-select counter (saturating)

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_sel  input  2  destination: 0→A, 1→B, 2→C, 3→illegal
- in_data  input  DATA_W  payload
- out_valid  output  3  per-channel valid; bit0=A, bit1=B, bit2=C
- out_ready  input  3  per-channel ready
- out_data  output  3*DATA_W  per-channel payload; slice k = [k*DATA_W +: DATA_W]
- err_pulse  output  1  one-cycle pulse, registered, for each dropped illegal beat
- err_flag  output  1  sticky illegal-select flag
- err_cnt  output  ERR_CNT_W  illegal beats seen; saturates at all-ones
- err_clr  input  1  synchronous clear of err_flag and err_cnt

## Operation
- Reset values: out_valid=0, out_data=0, err_pulse=0, err_flag=0, err_cnt=0.
- Channel k is free when !out_valid[k] || out_ready[k].
- in_ready is combinational:
  - in_sel 0..2: in_ready = free(in_sel).
  - in_sel 3: in_ready = 1. Illegal beats never stall.
- Accepted legal beat: out_data[k] loads in_data and out_valid[k] is set at the next edge.
- Channel k with out_valid[k] && out_ready[k] and no new load: out_valid[k] clears at the next edge.
- Load and drain in the same cycle: out_valid[k] stays 1 and data is replaced. This gives full throughput.
- Holding channel: out_data[k] is stable while out_valid[k] && !out_ready[k]. Channels are independent; a stalled channel does not block beats to other channels.
- Accepted illegal beat:
  - No channel changes.
  - err_pulse=1 for the next cycle.
  - err_flag is set.
  - err_cnt increments unless already all-ones.
- err_clr:
  - err_clr alone: err_flag=0, err_cnt=0 next cycle.
  - err_clr together with an accepted illegal beat: err_flag=1, err_cnt=1 (the new error wins over the clear).
- Mid-operation reset: all outputs return immediately to their reset values. Buffered beats are lost.
- in_data is don't-care when in_valid=0. in_sel is sampled only on an accepted beat.

## Timing
- Latency: accepted at edge N → out_valid[k]=1 after edge N, i.e. visible in cycle N+1.
- Sustained rate: 1 beat/cycle per channel while that channel's out_ready is held high.
- in_ready→in_valid: no combinational path. in_ready depends only on in_sel, out_valid and out_ready.
- out_ready→in_ready: one combinational path, through the free term.
- err_pulse: asserted in the cycle after acceptance, width exactly one cycle per illegal beat. Back-to-back illegal beats give a continuous high.

## Structure
- Package demux_pkg holds:
  - Enum dest_e with values DEST_A=2'd0, DEST_B=2'd1, DEST_C=2'd2, DEST_ILLEGAL=2'd3.
  - Localparam NUM_CH=3.
- Routing uses unique case on dest_e with a default arm for DEST_ILLEGAL, so a simulation warning flags any overlap.
- Sub-module demux_out_reg: one-entry valid/ready output register (parameter DATA_W; ports load, load_data, out_ready, out_valid, out_data, free). The top instantiates it 3 times.

## Test plan
- Reset release, then in_sel=0, in_data=8'h5A, out_ready=3'b111 → out_valid=3'b001 and out_data[A]=8'h5A one cycle later; pulse width 1.
- Stall channel B (out_ready[1]=0); send 8'h11 to B, then 8'h22 to B, then 8'h33 to C → in_ready=0 on the second B beat. C still receives 8'h33 the next cycle. B holds 8'h11 until ready, then 8'h22 follows.
- Stream 4 consecutive beats to A with out_ready[0]=1 → in_ready stays 1 throughout and A emits them on 4 consecutive cycles in order.
- in_sel=3 for 3 consecutive beats → no out_valid change, in_ready=1, err_pulse high 3 cycles, err_cnt=3, err_flag=1.
- Drive err_cnt to 255 (ERR_CNT_W=8), then one more illegal beat → err_cnt stays 255. Then err_clr concurrent with an illegal beat → err_cnt=1, err_flag=1.
- Assert rst_n=0 mid-stream with out_valid=3'b101 → all outputs 0 immediately, before the next clk edge.
